// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pkg : shared defaults and queue entry type for the fetch unit         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package fetch_pkg;

    localparam int unsigned DEFAULT_XLEN     = 64;
    localparam int unsigned DEFAULT_ILEN     = 32;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_ILEN-1:0] inst;
        logic                    filled;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue : in-order fetch buffer with allocate / fill / pop pointers     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module fetch_queue #(
    parameter int unsigned XLEN  = fetch_pkg::DEFAULT_XLEN,
    parameter int unsigned ILEN  = fetch_pkg::DEFAULT_ILEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic                     fill,
    input  logic [ILEN-1:0]          fill_inst,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [XLEN-1:0]          head_pc,
    output logic [ILEN-1:0]          head_inst,
    output logic [$clog2(DEPTH):0]   alloc_count,
    output logic [$clog2(DEPTH):0]   unfilled_count
);
    import fetch_pkg::*;

    localparam int c_IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            filled;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [c_IDX_W:0] r_tail;
    logic [c_IDX_W:0] r_fill;
    logic [c_IDX_W:0] r_head;

    wire [c_IDX_W-1:0] w_tail_idx = r_tail[c_IDX_W-1:0];
    wire [c_IDX_W-1:0] w_fill_idx = r_fill[c_IDX_W-1:0];
    wire [c_IDX_W-1:0] w_head_idx = r_head[c_IDX_W-1:0];

    // Entries head..fill-1 are filled, fill..tail-1 are awaiting their response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tail <= '0;
            r_fill <= '0;
            r_head <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head <= r_tail;
            r_fill <= r_tail;
        end else begin
            if (alloc) begin
                r_mem[w_tail_idx].pc     <= alloc_pc;
                r_mem[w_tail_idx].filled <= 1'b0;
                r_tail                   <= r_tail + 1'b1;
            end
            if (fill) begin
                r_mem[w_fill_idx].inst   <= fill_inst;
                r_mem[w_fill_idx].filled <= 1'b1;
                r_fill                   <= r_fill + 1'b1;
            end
            if (pop) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

    assign head_valid     = (r_head != r_fill) && r_mem[w_head_idx].filled;
    assign head_pc        = r_mem[w_head_idx].pc;
    assign head_inst      = r_mem[w_head_idx].inst;
    assign alloc_count    = r_tail - r_head;
    assign unfilled_count = r_tail - r_fill;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit : fetch PC, request credit and redirect/drop control             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module fetch_unit #(
    parameter int unsigned     XLEN     = fetch_pkg::DEFAULT_XLEN,
    parameter int unsigned     ILEN     = fetch_pkg::DEFAULT_ILEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_pkg::DEFAULT_RESET_PC),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);
    import fetch_pkg::*;

    localparam int                c_PTR_W   = $clog2(DEPTH) + 1;
    localparam logic [c_PTR_W:0]  c_DEPTH   = (c_PTR_W + 1)'(DEPTH);
    localparam logic [XLEN-1:0]   c_PC_STEP = XLEN'(4);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [c_PTR_W-1:0] r_drop_cnt;
    logic [c_PTR_W-1:0] w_alloc_count;
    logic [c_PTR_W-1:0] w_unfilled_count;
    logic [c_PTR_W:0]   w_credit_used;
    logic               w_req_fire;
    logic               w_resp_drop;
    logic               w_fill;
    logic               w_pop;

    // Responses still owed for flushed requests occupy credit until they return.
    assign w_credit_used  = {1'b0, w_alloc_count} + {1'b0, r_drop_cnt};
    assign imem_req_valid = rst_n && !redirect_valid && (w_credit_used < c_DEPTH);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_resp_drop    = (r_drop_cnt != '0);
    assign w_fill         = imem_resp_valid && !w_resp_drop && !redirect_valid;
    assign w_pop          = inst_valid && inst_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            r_drop_cnt <= r_drop_cnt + w_unfilled_count
                          - {{(c_PTR_W-1){1'b0}}, imem_resp_valid};
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + c_PC_STEP;
            end
            if (imem_resp_valid && w_resp_drop) begin
                r_drop_cnt <= r_drop_cnt - {{(c_PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (redirect_valid),
        .alloc          (w_req_fire),
        .alloc_pc       (r_fetch_pc),
        .fill           (w_fill),
        .fill_inst      (imem_resp_data),
        .pop            (w_pop),
        .head_valid     (inst_valid),
        .head_pc        (inst_pc),
        .head_inst      (inst),
        .alloc_count    (w_alloc_count),
        .unfilled_count (w_unfilled_count)
    );

    always @(posedge clk) begin
        if (rst_n && imem_resp_valid) begin
            assert (w_resp_drop || (w_unfilled_count != '0))
                else $error("fetch_unit: response with no outstanding request");
        end
    end

endmodule
`default_nettype wire
